// File: rtl/ecall_halt_stat_unit_pkg.sv
// Shared run-state encoding and default ECALL service codes for the ECALL halt/stat unit.
// Optional build macro: STAT_SATURATE_EN (the package itself has no conditional content).
package ecall_halt_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        HALT  = 2'd2
    } run_state_e;

    localparam logic [31:0] HALT_CODE_DEF  = 32'd10;
    localparam logic [31:0] PAUSE_CODE_DEF = 32'd50;

endpackage

// File: rtl/ecall_halt_stat_unit_if.sv
// Decode-strobe / run-control / statistics bundle between the datapath and the ECALL unit.
// Optional build macro: STAT_SATURATE_EN adds the sticky Stat_Overflow flag.
interface ecall_halt_stat_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 Ecall_Match;
    logic                 Branch_Match;
    logic                 Branch_Taken;
    logic                 Jump_Match;
    logic [31:0]          A7;
    logic [31:0]          A0;
    logic                 Go;
    logic                 Halt;
    logic [31:0]          Led_Data;
    logic [CNT_WIDTH-1:0] Total_Cycles;
    logic [CNT_WIDTH-1:0] Cond_Cnt;
    logic [CNT_WIDTH-1:0] Taken_Cnt;
    logic [CNT_WIDTH-1:0] Jump_Cnt;
`ifdef STAT_SATURATE_EN
    logic                 Stat_Overflow;
`endif

    modport master (
        output Ecall_Match, Branch_Match, Branch_Taken, Jump_Match, A7, A0, Go,
        input  Halt, Led_Data, Total_Cycles, Cond_Cnt, Taken_Cnt, Jump_Cnt
`ifdef STAT_SATURATE_EN
        , input Stat_Overflow
`endif
    );

    modport slave (
        input  Ecall_Match, Branch_Match, Branch_Taken, Jump_Match, A7, A0, Go,
        output Halt, Led_Data, Total_Cycles, Cond_Cnt, Taken_Cnt, Jump_Cnt
`ifdef STAT_SATURATE_EN
        , output Stat_Overflow
`endif
    );

endinterface

// File: rtl/ecall_halt_stat_unit_stat_counter.sv
// Single statistics counter: wraps by default, sticks at all-ones when STAT_SATURATE_EN is defined.
module stat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Inc,
    output logic [WIDTH-1:0] Count
`ifdef STAT_SATURATE_EN
    , output logic           Sat
`endif
);

`ifdef STAT_SATURATE_EN
    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ALMOST = {{(WIDTH-1){1'b1}}, 1'b0};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
            Sat   <= 1'b0;
        end else if (Inc) begin
            if (Count != CNT_MAX) Count <= Count + 1'b1;
            // Flag the moment the counter lands on all-ones; it never clears until reset.
            if (Count == CNT_ALMOST) Sat <= 1'b1;
        end
    end
`else
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else if (Inc) begin
            Count <= Count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ecall_halt_stat_unit.sv
// ECALL run-control (halt / pause-until-Go / LED latch) plus cycle and branch statistics.
// Optional build macro: STAT_SATURATE_EN makes counters saturate and drives Stat_Overflow.
module ecall_halt_stat_unit
    import ecall_halt_pkg::*;
#(
    parameter int          CNT_WIDTH   = 32,
    parameter logic [31:0] HALT_CODE   = HALT_CODE_DEF,
    parameter logic [31:0] PAUSE_CODE  = PAUSE_CODE_DEF,
    parameter int          SYNC_STAGES = 2
) (
    input logic                  Clock,
    input logic                  Reset,
    ecall_halt_stat_unit_if.slave bus
);

    run_state_e             state;
    logic                   resume_skip;
    logic [31:0]            led_q;
    logic [SYNC_STAGES-1:0] go_sync;
    logic                   go_prev;
    logic                   go_rise;

    logic in_run, ecall_run, is_halt_code, is_pause_code;
    logic halt_now, pause_now, disp_now, stop, count_en;

    // Go is an asynchronous button; only a fresh synchronized rising edge resumes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            go_sync <= '0;
            go_prev <= 1'b0;
        end else begin
            go_sync <= {go_sync[SYNC_STAGES-2:0], bus.Go};
            go_prev <= go_sync[SYNC_STAGES-1];
        end
    end

    assign go_rise = go_sync[SYNC_STAGES-1] & ~go_prev;

    always_comb begin
        in_run        = (state == RUN);
        ecall_run     = in_run & bus.Ecall_Match;
        is_halt_code  = (bus.A7 == HALT_CODE);
        is_pause_code = (bus.A7 == PAUSE_CODE);
        halt_now      = ecall_run & is_halt_code;
        // The PC still points at the pausing ECALL after resume, so it must not fire twice.
        pause_now     = ecall_run & is_pause_code & ~resume_skip;
        disp_now      = ecall_run & ~is_halt_code & ~is_pause_code;
        stop          = ~in_run | halt_now | pause_now;
        count_en      = in_run & ~stop;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= RUN;
            resume_skip <= 1'b0;
            led_q       <= '0;
        end else begin
            resume_skip <= 1'b0;
            if (disp_now) led_q <= bus.A0;
            case (state)
                RUN: begin
                    if (halt_now)       state <= HALT;
                    else if (pause_now) state <= PAUSE;
                end
                PAUSE: begin
                    if (go_rise) begin
                        state       <= RUN;
                        resume_skip <= 1'b1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.Halt     = stop;
    assign bus.Led_Data = led_q;

`ifdef STAT_SATURATE_EN
    logic [3:0] sat;
    assign bus.Stat_Overflow = |sat;
`endif

    stat_counter #(.WIDTH(CNT_WIDTH)) u_total (
        .Clock (Clock), .Reset (Reset), .Inc (count_en), .Count (bus.Total_Cycles)
`ifdef STAT_SATURATE_EN
        , .Sat (sat[0])
`endif
    );

    stat_counter #(.WIDTH(CNT_WIDTH)) u_cond (
        .Clock (Clock), .Reset (Reset), .Inc (count_en & bus.Branch_Match), .Count (bus.Cond_Cnt)
`ifdef STAT_SATURATE_EN
        , .Sat (sat[1])
`endif
    );

    stat_counter #(.WIDTH(CNT_WIDTH)) u_taken (
        .Clock (Clock), .Reset (Reset), .Inc (count_en & bus.Branch_Match & bus.Branch_Taken),
        .Count (bus.Taken_Cnt)
`ifdef STAT_SATURATE_EN
        , .Sat (sat[2])
`endif
    );

    stat_counter #(.WIDTH(CNT_WIDTH)) u_jump (
        .Clock (Clock), .Reset (Reset), .Inc (count_en & bus.Jump_Match), .Count (bus.Jump_Cnt)
`ifdef STAT_SATURATE_EN
        , .Sat (sat[3])
`endif
    );

endmodule

// File: tb/tb_ecall_halt_stat_unit.sv
// Self-checking bench for ecall_halt_stat_unit (32-bit instance plus a 4-bit wrap/saturate instance).
// Honours STAT_SATURATE_EN for the saturation expectations.
module tb_ecall_halt_stat_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int unsigned total;
        int unsigned cond;
        int unsigned taken;
        int unsigned jump;
        logic        halt;
    } snap_t;

    snap_t       sb_q[$];
    logic [31:0] led_q[$];

    ecall_halt_stat_unit_if #(.CNT_WIDTH(32)) bus ();
    ecall_halt_stat_unit_if #(.CNT_WIDTH(4))  bus4 ();

    ecall_halt_stat_unit #(.CNT_WIDTH(32)) dut (.Clock(clk), .Reset(rst), .bus(bus));
    ecall_halt_stat_unit #(.CNT_WIDTH(4))  dut4 (.Clock(clk), .Reset(rst), .bus(bus4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Ecall_Match = 0; bus.Branch_Match = 0; bus.Branch_Taken = 0; bus.Jump_Match = 0;
        bus.A7 = '0; bus.A0 = '0; bus.Go = 0;
        bus4.Ecall_Match = 0; bus4.Branch_Match = 0; bus4.Branch_Taken = 0; bus4.Jump_Match = 0;
        bus4.A7 = '0; bus4.A0 = '0; bus4.Go = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if (bus.Halt !== 1'b0) $display("FAIL reset_halt got %0b want 0", bus.Halt); else n_pass++;
        n_total++; if (bus.Led_Data !== 32'd0) $display("FAIL reset_led got %h want 0", bus.Led_Data); else n_pass++;
        n_total++; if (bus.Total_Cycles !== 32'd0) $display("FAIL reset_total got %0d want 0", bus.Total_Cycles); else n_pass++;
        n_total++; if (bus.Cond_Cnt !== 32'd0 || bus.Taken_Cnt !== 32'd0 || bus.Jump_Cnt !== 32'd0)
            $display("FAIL reset_branch_cnts got %0d/%0d/%0d want 0/0/0", bus.Cond_Cnt, bus.Taken_Cnt, bus.Jump_Cnt);
        else n_pass++;
        repeat (5) tick();
        n_total++; if (bus.Total_Cycles !== 32'd5) $display("FAIL run5_total got %0d want 5", bus.Total_Cycles); else n_pass++;
        n_total++; if (bus.Halt !== 1'b0) $display("FAIL run5_halt got %0b want 0", bus.Halt); else n_pass++;
    endtask

    task automatic test_display();
        int unsigned exp_total;
        logic [31:0] exp_led;
        exp_total = 5;
        bus.Ecall_Match = 1; bus.A7 = 32'd1; bus.A0 = 32'h1234ABCD;
        led_q.push_back(32'h1234ABCD);
        #1;
        n_total++; if (bus.Halt !== 1'b0) $display("FAIL disp1_halt got %0b want 0", bus.Halt); else n_pass++;
        tick(); exp_total++;
        bus.Ecall_Match = 0; bus.A0 = 32'h0BAD0BAD;
        exp_led = led_q.pop_front();
        n_total++; if (bus.Led_Data !== exp_led) $display("FAIL disp1_led got %h want %h", bus.Led_Data, exp_led); else n_pass++;
        n_total++; if (bus.Total_Cycles !== exp_total) $display("FAIL disp1_total got %0d want %0d", bus.Total_Cycles, exp_total); else n_pass++;
        tick(); exp_total++;
        n_total++; if (bus.Led_Data !== exp_led) $display("FAIL disp_hold_led got %h want %h", bus.Led_Data, exp_led); else n_pass++;
        bus.Ecall_Match = 1; bus.A7 = 32'd11; bus.A0 = 32'hDEADBEEF;
        led_q.push_back(32'hDEADBEEF);
        tick(); exp_total++;
        bus.Ecall_Match = 0;
        exp_led = led_q.pop_front();
        n_total++; if (bus.Led_Data !== exp_led) $display("FAIL disp2_led got %h want %h", bus.Led_Data, exp_led); else n_pass++;
        n_total++; if (bus.Total_Cycles !== exp_total) $display("FAIL disp2_total got %0d want %0d", bus.Total_Cycles, exp_total); else n_pass++;
    endtask

    task automatic test_halt();
        // Continues from test_display: 8 counted cycles, LED holds DEADBEEF.
        bus.Ecall_Match = 1; bus.A7 = 32'd10; bus.A0 = 32'h55;
        #1;
        n_total++; if (bus.Halt !== 1'b1) $display("FAIL halt_same_cycle got %0b want 1", bus.Halt); else n_pass++;
        tick();
        bus.Ecall_Match = 0; bus.Branch_Match = 1; bus.Branch_Taken = 1; bus.Jump_Match = 1;
        for (int i = 0; i < 3; i++) begin
            bus.Go = 1; repeat (4) tick();
            bus.Go = 0; repeat (4) tick();
        end
        n_total++; if (bus.Halt !== 1'b1) $display("FAIL halt_sticky got %0b want 1", bus.Halt); else n_pass++;
        n_total++; if (bus.Total_Cycles !== 32'd8) $display("FAIL halt_total_frozen got %0d want 8", bus.Total_Cycles); else n_pass++;
        n_total++; if (bus.Cond_Cnt !== 32'd0 || bus.Jump_Cnt !== 32'd0)
            $display("FAIL halt_branch_frozen got %0d/%0d want 0/0", bus.Cond_Cnt, bus.Jump_Cnt);
        else n_pass++;
        n_total++; if (bus.Led_Data !== 32'hDEADBEEF) $display("FAIL halt_led_hold got %h want deadbeef", bus.Led_Data); else n_pass++;
        apply_reset();
        n_total++; if (bus.Halt !== 1'b0) $display("FAIL halt_reset_halt got %0b want 0", bus.Halt); else n_pass++;
        n_total++; if (bus.Total_Cycles !== 32'd0) $display("FAIL halt_reset_total got %0d want 0", bus.Total_Cycles); else n_pass++;
        n_total++; if (bus.Led_Data !== 32'd0) $display("FAIL halt_reset_led got %h want 0", bus.Led_Data); else n_pass++;
    endtask

    task automatic test_pause();
        apply_reset();
        bus.Go = 1;
        repeat (4) tick();
        bus.Ecall_Match = 1; bus.A7 = 32'd50; bus.A0 = 32'h99;
        #1;
        n_total++; if (bus.Halt !== 1'b1) $display("FAIL pause_entry got %0b want 1", bus.Halt); else n_pass++;
        repeat (3) tick();
        bus.Go = 0;
        repeat (4) tick();
        n_total++; if (bus.Halt !== 1'b1) $display("FAIL pause_go_held got %0b want 1", bus.Halt); else n_pass++;
        bus.Go = 1;
        tick();
        n_total++; if (bus.Halt !== 1'b1) $display("FAIL pause_rise_edge1 got %0b want 1", bus.Halt); else n_pass++;
        tick();
        n_total++; if (bus.Halt !== 1'b1) $display("FAIL pause_rise_edge2 got %0b want 1", bus.Halt); else n_pass++;
        tick();
        n_total++; if (bus.Halt !== 1'b0) $display("FAIL pause_resume got %0b want 0", bus.Halt); else n_pass++;
        tick();
        bus.Ecall_Match = 0;
        #1;
        n_total++; if (bus.Total_Cycles !== 32'd5) $display("FAIL pause_total got %0d want 5", bus.Total_Cycles); else n_pass++;
        n_total++; if (bus.Halt !== 1'b0) $display("FAIL pause_after_resume got %0b want 0", bus.Halt); else n_pass++;
        n_total++; if (bus.Led_Data !== 32'd0) $display("FAIL pause_led got %h want 0", bus.Led_Data); else n_pass++;
        bus.Go = 0;
    endtask

    task automatic test_branches();
        // {branch_match, branch_taken, jump_match, ecall, a7}
        logic [3:0]  row_f[9];
        logic [31:0] row_a7[9];
        snap_t m, exp_s;
        row_f[0] = 4'b1100; row_f[1] = 4'b1000; row_f[2] = 4'b1100;
        row_f[3] = 4'b0010; row_f[4] = 4'b0010; row_f[5] = 4'b0100;
        row_f[6] = 4'b1110; row_f[7] = 4'b1001; row_f[8] = 4'b1111;
        for (int i = 0; i < 9; i++) row_a7[i] = 32'd0;
        row_a7[7] = 32'd3;
        row_a7[8] = 32'd10;
        apply_reset();
        m = '{total: 0, cond: 0, taken: 0, jump: 0, halt: 1'b0};
        for (int i = 0; i < 9; i++) begin
            bus.Branch_Match = row_f[i][3]; bus.Branch_Taken = row_f[i][2];
            bus.Jump_Match   = row_f[i][1]; bus.Ecall_Match  = row_f[i][0];
            bus.A7 = row_a7[i]; bus.A0 = 32'hC0DE0000 + i;
            m.halt = row_f[i][0] && (row_a7[i] == 32'd10 || row_a7[i] == 32'd50);
            if (!m.halt) begin
                m.total++;
                if (row_f[i][3]) m.cond++;
                if (row_f[i][3] && row_f[i][2]) m.taken++;
                if (row_f[i][1]) m.jump++;
            end
            sb_q.push_back(m);
            #1;
            n_total++; if (bus.Halt !== m.halt) $display("FAIL br_halt[%0d] got %0b want %0b", i, bus.Halt, m.halt); else n_pass++;
            tick();
            exp_s = sb_q.pop_front();
            n_total++;
            if (bus.Total_Cycles !== exp_s.total || bus.Cond_Cnt !== exp_s.cond ||
                bus.Taken_Cnt !== exp_s.taken || bus.Jump_Cnt !== exp_s.jump)
                $display("FAIL br_cnts[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                         bus.Total_Cycles, bus.Cond_Cnt, bus.Taken_Cnt, bus.Jump_Cnt,
                         exp_s.total, exp_s.cond, exp_s.taken, exp_s.jump);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_saturate();
        logic [3:0] exp_final;
`ifdef STAT_SATURATE_EN
        exp_final = 4'd15;
`else
        exp_final = 4'd4;
`endif
        apply_reset();
        repeat (14) tick();
        n_total++; if (bus4.Total_Cycles !== 4'd14) $display("FAIL w4_total14 got %0d want 14", bus4.Total_Cycles); else n_pass++;
`ifdef STAT_SATURATE_EN
        n_total++; if (bus4.Stat_Overflow !== 1'b0) $display("FAIL w4_ovf_early got %0b want 0", bus4.Stat_Overflow); else n_pass++;
`endif
        repeat (6) tick();
        n_total++; if (bus4.Total_Cycles !== exp_final) $display("FAIL w4_total20 got %0d want %0d", bus4.Total_Cycles, exp_final); else n_pass++;
        n_total++; if (bus4.Cond_Cnt !== 4'd0) $display("FAIL w4_cond got %0d want 0", bus4.Cond_Cnt); else n_pass++;
`ifdef STAT_SATURATE_EN
        n_total++; if (bus4.Stat_Overflow !== 1'b1) $display("FAIL w4_ovf got %0b want 1", bus4.Stat_Overflow); else n_pass++;
        n_total++; if (bus.Stat_Overflow !== 1'b0) $display("FAIL w32_ovf got %0b want 0", bus.Stat_Overflow); else n_pass++;
`endif
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_display();
        test_halt();
        test_pause();
        test_branches();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
